// File: rtl/mem_arbiter_rr.sv
// Round-robin shared-memory arbiter with a round-robin hardware mutex port.
// Optional macro MEM_ARB_OWNER_CHECK_EN: unlock only succeeds for the owning channel.
module mem_arbiter_rr #(
    parameter int C  = 8,
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int LW = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [C-1:0]         req,
    input  logic [C-1:0]         we,
    input  logic [C-1:0][AW-1:0] adr,
    input  logic [C-1:0][DW-1:0] wdat,
    output logic [C-1:0]         gnt,
    output logic [C-1:0]         rvalid,
    output logic [DW-1:0]        rdata,
    input  logic [C-1:0]         lock_req,
    input  logic [C-1:0]         lock_op,
    input  logic [C-1:0][LW-1:0] lock_id,
    output logic [C-1:0]         lock_ack,
    output logic                 lock_ok
);
    localparam int PW = $clog2(C);

    logic [DW-1:0]      mem [2**AW];
    logic [2**LW-1:0]   busy;
`ifdef MEM_ARB_OWNER_CHECK_EN
    logic [PW-1:0]      owner [2**LW];
`endif

    logic [PW-1:0] mptr, lptr;
    logic          mem_found, lock_found;
    logic [PW-1:0] mem_sel, lock_sel;
    logic [C-1:0]  mem_oh, lock_oh, lock_elig;
    logic [LW-1:0] lk_id;
    logic          lk_try, lk_ok;

    // Explicit modulo-C wrap so non-power-of-two channel counts work.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= C) s = s - C;
        return PW'(s);
    endfunction

    always_comb begin
        mem_found = 1'b0;
        mem_sel   = '0;
        for (int i = 0; i < C; i++) begin
            if (!mem_found && req[wrap_add(mptr, i)]) begin
                mem_found = 1'b1;
                mem_sel   = wrap_add(mptr, i);
            end
        end
        mem_oh          = '0;
        mem_oh[mem_sel] = mem_found;
        gnt             = reset ? mem_oh : '0;
    end

    // A channel whose ack is currently visible is masked so it cannot execute twice.
    always_comb begin
        lock_elig  = lock_req & ~lock_ack;
        lock_found = 1'b0;
        lock_sel   = '0;
        for (int i = 0; i < C; i++) begin
            if (!lock_found && lock_elig[wrap_add(lptr, i)]) begin
                lock_found = 1'b1;
                lock_sel   = wrap_add(lptr, i);
            end
        end
        lock_oh           = '0;
        lock_oh[lock_sel] = lock_found;
        lk_id             = lock_id[lock_sel];
        lk_try            = lock_op[lock_sel];
        if (lk_try) begin
            lk_ok = !busy[lk_id];
        end else begin
`ifdef MEM_ARB_OWNER_CHECK_EN
            lk_ok = busy[lk_id] && (owner[lk_id] == lock_sel);
`else
            lk_ok = busy[lk_id];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mptr     <= '0;
            lptr     <= '0;
            rvalid   <= '0;
            rdata    <= '0;
            lock_ack <= '0;
            lock_ok  <= 1'b0;
            busy     <= '0;
`ifdef MEM_ARB_OWNER_CHECK_EN
            for (int i = 0; i < 2**LW; i++) owner[i] <= '0;
`endif
        end else begin
            rvalid <= '0;
            if (mem_found) begin
                mptr <= wrap_add(mem_sel, 1);
                if (!we[mem_sel]) begin
                    rvalid <= mem_oh;
                    rdata  <= mem[adr[mem_sel]];
                end
            end
            lock_ack <= '0;
            if (lock_found) begin
                lptr     <= wrap_add(lock_sel, 1);
                lock_ack <= lock_oh;
                lock_ok  <= lk_ok;
                if (lk_ok) busy[lk_id] <= lk_try;
`ifdef MEM_ARB_OWNER_CHECK_EN
                if (lk_ok && lk_try) owner[lk_id] <= lock_sel;
`endif
            end
        end
    end

    // NOTE: the data array has no reset; clearing 2**AW words is not wanted and blocks RAM inference.
    always_ff @(posedge clk) begin
        if (reset && mem_found && we[mem_sel]) mem[adr[mem_sel]] <= wdat[mem_sel];
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed self-checking bench for mem_arbiter_rr (C=8, AW=16, DW=16, LW=10).
// Works with or without MEM_ARB_OWNER_CHECK_EN defined.
module tb_mem_arbiter_rr;
    localparam int C  = 8;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LW = 10;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [C-1:0]         req, we, gnt, rvalid;
    logic [C-1:0][AW-1:0] adr;
    logic [C-1:0][DW-1:0] wdat;
    logic [DW-1:0]        rdata;
    logic [C-1:0]         lock_req, lock_op, lock_ack;
    logic [C-1:0][LW-1:0] lock_id;
    logic                 lock_ok;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter_rr #(.C(C), .AW(AW), .DW(DW), .LW(LW)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .adr(adr), .wdat(wdat),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .lock_req(lock_req), .lock_op(lock_op), .lock_id(lock_id),
        .lock_ack(lock_ack), .lock_ok(lock_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [C-1:0]  req;
        logic [C-1:0]  we;
        logic [C-1:0]  gnt;
        logic [C-1:0]  rvalid;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [C-1:0] r, input logic [C-1:0] w,
                                input logic [C-1:0] g, input logic [C-1:0] rv,
                                input logic [DW-1:0] rd);
        vec_t v;
        v.req = r; v.we = w; v.gnt = g; v.rvalid = rv; v.rdata = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic lock_step(input string name, input logic [C-1:0] exp_ack, input logic exp_ok);
        edge_step();
        check({name, " ack"}, lock_ack, exp_ack);
        check({name, " ok"}, lock_ok, exp_ok);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Arbitration table, entered with mptr=3; adr[k]=0x0100+k, wdat[k]=0xA000+k.
        vecs.push_back(mk(8'hFF, 8'hFF, 8'h08, 8'h00, 16'h0));
        vecs.push_back(mk(8'hFF, 8'hFF, 8'h10, 8'h00, 16'h0));
        vecs.push_back(mk(8'hFF, 8'hFF, 8'h20, 8'h00, 16'h0));
        vecs.push_back(mk(8'hFF, 8'hFF, 8'h40, 8'h00, 16'h0));
        vecs.push_back(mk(8'hFF, 8'hFF, 8'h80, 8'h00, 16'h0));
        vecs.push_back(mk(8'hFF, 8'hFF, 8'h01, 8'h00, 16'h0));
        vecs.push_back(mk(8'hFF, 8'hFF, 8'h02, 8'h00, 16'h0));
        vecs.push_back(mk(8'hFF, 8'hFF, 8'h04, 8'h00, 16'h0));
        vecs.push_back(mk(8'h80, 8'h00, 8'h80, 8'h80, 16'hA007));  // moves mptr to 0
        vecs.push_back(mk(8'hFF, 8'h00, 8'h01, 8'h01, 16'hA000));  // fairness ch0..ch7, ch0
        vecs.push_back(mk(8'hFF, 8'h00, 8'h02, 8'h02, 16'hA001));
        vecs.push_back(mk(8'hFF, 8'h00, 8'h04, 8'h04, 16'hA002));
        vecs.push_back(mk(8'hFF, 8'h00, 8'h08, 8'h08, 16'hA003));
        vecs.push_back(mk(8'hFF, 8'h00, 8'h10, 8'h10, 16'hA004));
        vecs.push_back(mk(8'hFF, 8'h00, 8'h20, 8'h20, 16'hA005));
        vecs.push_back(mk(8'hFF, 8'h00, 8'h40, 8'h40, 16'hA006));
        vecs.push_back(mk(8'hFF, 8'h00, 8'h80, 8'h80, 16'hA007));
        vecs.push_back(mk(8'hFF, 8'h00, 8'h01, 8'h01, 16'hA000));
        vecs.push_back(mk(8'h20, 8'h00, 8'h20, 8'h20, 16'hA005));  // moves mptr to 6
        vecs.push_back(mk(8'h05, 8'h00, 8'h01, 8'h01, 16'hA000));  // wrap and skip
        vecs.push_back(mk(8'h05, 8'h00, 8'h04, 8'h04, 16'hA002));
        vecs.push_back(mk(8'h05, 8'h00, 8'h01, 8'h01, 16'hA000));
        vecs.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 16'h0));     // idle: pointer holds at 1
        vecs.push_back(mk(8'h02, 8'h00, 8'h02, 8'h02, 16'hA001));

        reset    = 1'b0;
        req      = 8'h01;
        we       = '0;
        adr      = '0;
        wdat     = '0;
        lock_req = 8'h01;
        lock_op  = 8'h01;
        lock_id  = '0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("reset%0d gnt", i), gnt, 8'h00);
            edge_step();
            check($sformatf("reset%0d rvalid", i), rvalid, 8'h00);
            check($sformatf("reset%0d lock_ack", i), lock_ack, 8'h00);
            check($sformatf("reset%0d rdata", i), rdata, 16'h0);
        end
        req      = '0;
        lock_req = '0;
        lock_op  = '0;
        reset    = 1'b1;

        // ch2 preload write then read back.
        req = 8'h04; we = 8'h04; adr[2] = 16'h0040; wdat[2] = 16'hBEEF;
        @(negedge clk);
        check("preload gnt", gnt, 8'h04);
        edge_step();
        check("preload rvalid", rvalid, 8'h00);
        we = 8'h00;
        @(negedge clk);
        check("read gnt", gnt, 8'h04);
        edge_step();
        check("read rvalid", rvalid, 8'h04);
        check("read rdata", rdata, 16'hBEEF);
        req = '0;
        for (int k = 0; k < C; k++) begin
            adr[k]  = AW'(16'h0100 + k);
            wdat[k] = DW'(16'hA000 + k);
        end

        foreach (vecs[i]) begin
            req = vecs[i].req;
            we  = vecs[i].we;
            @(negedge clk);
            check($sformatf("vec%0d gnt", i), gnt, vecs[i].gnt);
            edge_step();
            check($sformatf("vec%0d rvalid", i), rvalid, vecs[i].rvalid);
            if (vecs[i].rvalid != '0)
                check($sformatf("vec%0d rdata", i), rdata, vecs[i].rdata);
        end
        req = '0;
        we  = '0;

        // Lock contention on 0x3FF, lptr=0.
        lock_req = 8'h0A; lock_op = 8'h0A; lock_id[1] = 10'h3FF; lock_id[3] = 10'h3FF;
        lock_step("contend ch1", 8'h02, 1'b1);
        lock_req[1] = 1'b0;
        lock_step("contend ch3", 8'h08, 1'b0);
        lock_req[3] = 1'b0; lock_req[1] = 1'b1; lock_op[1] = 1'b0;
        lock_step("unlock ch1", 8'h02, 1'b1);
        lock_req[1] = 1'b0; lock_req[3] = 1'b1;
        lock_step("retry ch3", 8'h08, 1'b1);
        lock_step("ack mask ch3", 8'h00, 1'b1);  // ch3 still requesting while its ack is visible
        lock_req = '0;

        // Foreign unlock of id 5, lptr=4.
        lock_req = 8'h01; lock_op = 8'h01; lock_id[0] = 10'd5;
        lock_step("lock ch0 id5", 8'h01, 1'b1);
        lock_req = 8'h10; lock_op = 8'h00; lock_id[4] = 10'd5;
`ifdef MEM_ARB_OWNER_CHECK_EN
        lock_step("foreign unlock ch4", 8'h10, 1'b0);
`else
        lock_step("foreign unlock ch4", 8'h10, 1'b1);
`endif
        lock_req = 8'h04; lock_op = 8'h04; lock_id[2] = 10'd5;
`ifdef MEM_ARB_OWNER_CHECK_EN
        lock_step("trylock ch2 id5", 8'h04, 1'b0);
`else
        lock_step("trylock ch2 id5", 8'h04, 1'b1);
`endif
        lock_req = 8'h40; lock_op = 8'h00; lock_id[6] = 10'd7;
        lock_step("unlock free ch6", 8'h40, 1'b0);
        lock_req = 8'h08; lock_op = 8'h08;
        lock_step("self trylock ch3", 8'h08, 1'b0);
        lock_req = '0;

        // Reset in the cycle after a read grant and a lock grant (mptr=2, lptr=4).
        req = 8'h02; lock_req = 8'h20; lock_op = 8'h20; lock_id[5] = 10'h3FF;
        @(negedge clk);
        check("pre-reset gnt", gnt, 8'h02);
        edge_step();
        check("pre-reset rvalid", rvalid, 8'h02);
        check("pre-reset lock_ack", lock_ack, 8'h20);
        reset = 1'b0;
        @(negedge clk);
        check("mid-reset gnt", gnt, 8'h00);
        edge_step();
        check("post-reset rvalid", rvalid, 8'h00);
        check("post-reset lock_ack", lock_ack, 8'h00);
        check("post-reset rdata", rdata, 16'h0);
        check("post-reset lock_ok", lock_ok, 1'b0);
        reset = 1'b1;
        req   = 8'h81;
        @(negedge clk);
        check("ptr reset gnt", gnt, 8'h01);
        edge_step();
        check("ptr reset rvalid", rvalid, 8'h01);
        check("mem kept rdata", rdata, 16'hA000);
        check("cleared table ack", lock_ack, 8'h20);
        check("cleared table ok", lock_ok, 1'b1);
        req      = '0;
        lock_req = '0;
        edge_step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
